pmod_ssd_driver: RTL
====================

// Module: pmod_ssd_driver
// PURPOSE
//   Display end of the PmodSSD path: accepts 8-bit values from the counter logic over a
//   valid/ready handshake and drives the two-digit multiplexed PmodSSD as two hex digits.
//   - Double-buffered: new values reach the display only at a frame boundary, so the
//     two digits never show a torn pair.
//   - Sits between the counter/datapath and the Pmod pins (segment bus plus digit-select C).
// PARAMETERS
//   DIGIT_TICKS    50_000  clk cycles each digit is driven (1 ms at 100 MHz); minimum 2
//   SEG_ACTIVE_LOW 0       1: invert seg outputs (lit = 0); all-off pattern becomes 7'h7F
// PORTS
//   clk         in   1  system clock (100 MHz); single clock domain
//   rst         in   1  synchronous, active-high reset
//   in_data     in   8  value to display; [7:4] tens/left digit, [3:0] ones/right digit
//   in_valid    in   1  in_data is valid
//   in_ready    out  1  block can accept in_data (= ~pend)
//   blank       in   1  1: force all segments off; multiplexing continues
//   seg         out  7  segments a..g, seg[0]=a .. seg[6]=g; active high unless SEG_ACTIVE_LOW
//   sel         out  1  PmodSSD C pin: 0 = ones (right) digit, 1 = tens (left) digit
//   frame_tick  out  1  1-cycle pulse at each frame boundary (sel 1->0)
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge): tick_cnt=0, sel=0, disp=8'h00, shadow=8'h00, pend=0,
//     frame_tick=0, seg=all-off.
//     - in_ready=1 from the first cycle after reset.
//     - Reset mid-pending drops the pending value.
//   - Divider: tick_cnt counts 0..DIGIT_TICKS-1 and wraps. On the terminal count, sel toggles.
//   - Frame end is the terminal count with sel==1 (sel going 1->0). On that edge:
//     - frame_tick=1 for exactly one cycle;
//     - if pend=1: disp<=shadow and pend<=0, so in_ready is high again the next cycle.
//   - Accept: on an edge where in_valid && in_ready, shadow<=in_data and pend<=1.
//     - in_ready is low from the next cycle.
//     - Held in_valid with in_ready=0 is not accepted; the producer holds in_data.
//   - Simultaneous accept and frame end: the transfer sees pend=0 (nothing moves). The new
//     value is shown from the following frame. No value is lost or duplicated.
//   - seg and sel update on the same edge; seg always shows the digit currently selected:
//     seg = decode(sel ? disp[7:4] : disp[3:0]).
//     - Latency from a disp update to seg: 0 cycles (same edge the new sel/seg are driven).
//   - blank=1 sampled at an edge: seg=all-off from that edge. Divider, sel and handshake
//     are unaffected. Deassert restores normal decode on the next edge.
//   - Hex decode (g..a as hex):
//     0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
//   - SEG_ACTIVE_LOW=1 inverts seg after decode and blanking.
//   - tick_cnt width is $clog2(DIGIT_TICKS). No other arithmetic; values are raw hex.
// CONFIGURATION
//   SSD_LZ_BLANK_EN defined: when sel=1 and disp[7:4]==4'h0, the tens digit shows
//     all-off (leading-zero blanking). The ones digit is always shown.
//   SSD_LZ_BLANK_EN undefined: the tens digit shows '0' (7'h3F) for disp[7:4]==0.
// TESTING (bench uses DIGIT_TICKS=4)
//   1. Reset/mux timing: rst=1 for 3 cycles -> seg=7'h00, sel=0, in_ready=1, frame_tick=0.
//      Then sel toggles every 4 cycles and frame_tick pulses every 8 cycles, coincident
//      with sel 1->0.
//   2. Single write: in_data=8'h3A, 1-cycle valid -> in_ready=0 next cycle. At the next
//      frame end, sel=0 shows 7'h77 and sel=1 shows 7'h4F. in_ready=1 the cycle after
//      the transfer.
//   3. Back-to-back: accept 8'h12, then hold valid with 8'h34 -> 8'h34 is accepted only
//      after 8'h12 is transferred. The display shows a full 12 frame, then a full 34 frame;
//      no 14/32 mix is ever seen.
//   4. Collision: assert valid 8'h56 on the exact frame-end edge with pend=0 -> accepted;
//      shown from the frame after next. disp is unchanged on that edge.
//   5. Blank and reset: blank=1 mid-digit -> seg=00 next edge, sel keeps toggling.
//      rst=1 while pend=1 -> pend=0, disp=00, in_ready=1.
//   6. Macro: in_data=8'h05 -> tens digit seg=7'h00 with SSD_LZ_BLANK_EN, 7'h3F without;
//      ones digit=7'h6D in both builds.

Source files
------------

// File: rtl/pmod_ssd_driver.sv
// Two-digit multiplexed PmodSSD driver with a double-buffered 8-bit hex display value.
// Optional build macro SSD_LZ_BLANK_EN enables leading-zero blanking of the tens digit.
module pmod_ssd_driver #(
    parameter int DIGIT_TICKS    = 50_000,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       sel,
    output logic       frame_tick
);
    // Handshake: a value transfers on any clk edge where in_valid && in_ready; the producer
    // holds in_data and in_valid until that edge, and in_ready never depends on in_valid.

    localparam int             CW      = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [CW-1:0]  LAST    = CW'(DIGIT_TICKS - 1);
    localparam logic [6:0]     SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [CW-1:0] tick_cnt, tick_nxt;
    logic [7:0]    disp, disp_nxt;
    logic [7:0]    shadow, shadow_nxt;
    logic          pend, pend_nxt;
    logic          sel_nxt, frame_end, terminal;
    logic [3:0]    nib;
    logic [6:0]    lit, seg_nxt;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0: hex_decode = 7'h3F;
            4'h1: hex_decode = 7'h06;
            4'h2: hex_decode = 7'h5B;
            4'h3: hex_decode = 7'h4F;
            4'h4: hex_decode = 7'h66;
            4'h5: hex_decode = 7'h6D;
            4'h6: hex_decode = 7'h7D;
            4'h7: hex_decode = 7'h07;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h6F;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h7C;
            4'hC: hex_decode = 7'h39;
            4'hD: hex_decode = 7'h5E;
            4'hE: hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    assign in_ready = ~pend;

    always_comb begin
        terminal   = (tick_cnt == LAST);
        tick_nxt   = terminal ? '0 : tick_cnt + CW'(1);
        sel_nxt    = sel ^ terminal;
        frame_end  = terminal & sel;
        disp_nxt   = disp;
        shadow_nxt = shadow;
        pend_nxt   = pend;
        // A frame-end transfer needs pend=1 while an accept needs pend=0, so they never overlap.
        if (frame_end && pend) begin
            disp_nxt = shadow;
            pend_nxt = 1'b0;
        end else if (in_valid && !pend) begin
            shadow_nxt = in_data;
            pend_nxt   = 1'b1;
        end
        // seg is decoded from the next-cycle sel/disp so both change on the same edge.
        nib = sel_nxt ? disp_nxt[7:4] : disp_nxt[3:0];
        lit = hex_decode(nib);
`ifdef SSD_LZ_BLANK_EN
        if (sel_nxt && (disp_nxt[7:4] == 4'h0)) lit = 7'h00;
`endif
        if (blank) lit = 7'h00;
        seg_nxt = SEG_ACTIVE_LOW ? ~lit : lit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt   <= '0;
            sel        <= 1'b0;
            disp       <= 8'h00;
            shadow     <= 8'h00;
            pend       <= 1'b0;
            frame_tick <= 1'b0;
            seg        <= SEG_OFF;
        end else begin
            tick_cnt   <= tick_nxt;
            sel        <= sel_nxt;
            disp       <= disp_nxt;
            shadow     <= shadow_nxt;
            pend       <= pend_nxt;
            frame_tick <= frame_end;
            seg        <= seg_nxt;
        end
    end

endmodule
